// File: rtl/reg_scoreboard_pkg.sv
// Shared widths and counter-operation encoding for the register reservation scoreboard.
package reg_scoreboard_pkg;

   localparam int W_RD_DEF  = 3;
   localparam int W_CNT_DEF = 2;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_INC  = 2'd1,
      OP_DEC  = 2'd2
   } cnt_op_e;

   // A simultaneous inc and dec cancel; saturated or empty counters hold.
   function automatic cnt_op_e cnt_op(input logic inc, input logic dec,
                                      input logic zero, input logic full);
      cnt_op_e op;
      op = OP_HOLD;
      if (inc && !dec && !full)
         op = OP_INC;
      else if (dec && !inc && !zero)
         op = OP_DEC;
      return op;
   endfunction

endpackage

// File: rtl/reg_scoreboard_pend_counter.sv
// Outstanding-write counter for one architectural register, with saturation status and
// overflow/underflow indications for the current cycle's request.
module pend_counter
   import reg_scoreboard_pkg::*;
#(
   parameter int W_CNT = W_CNT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic zero_o,
   output logic full_o,
   output logic ovf_o,
   output logic unf_o
);

   localparam logic [W_CNT-1:0] MAXP = '1;

   logic [W_CNT-1:0] cnt;
   cnt_op_e          op;

   assign zero_o = (cnt == '0);
   assign full_o = (cnt == MAXP);
   assign ovf_o  = inc & ~dec & full_o;
   assign unf_o  = dec & ~inc & zero_o;

   always_comb begin
      op = cnt_op(inc, dec, zero_o, full_o);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else begin
         case (op)
            OP_INC:  cnt <= cnt + 1'b1;
            OP_DEC:  cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Register reservation scoreboard: per-register pending-write counters and a
// conservative combinational hazard check for decode.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int W_RD  = W_RD_DEF,
   parameter int W_CNT = W_CNT_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            chk_v_i,
   input  logic [W_RD-1:0] chk_r0_i,
   input  logic [W_RD-1:0] chk_r1_i,
   input  logic            chk_r1en_i,
   input  logic            chk_wen_i,
   output logic            reserved_o,
   input  logic            set_v_i,
   input  logic [W_RD-1:0] set_r_i,
   input  logic            clr_v_i,
   input  logic [W_RD-1:0] clr_r_i,
   output logic            busy_o,
   output logic            err_o
);

   localparam int NREG = 1 << W_RD;

   logic [NREG-1:0] inc_vec;
   logic [NREG-1:0] dec_vec;
   logic [NREG-1:0] zero_vec;
   logic [NREG-1:0] full_vec;
   logic [NREG-1:0] ovf_vec;
   logic [NREG-1:0] unf_vec;
   logic            r0_busy;
   logic            r0_full;
   logic            r1_busy;
   logic            err;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int k = 0; k < NREG; k++) begin
         inc_vec[k] = set_v_i && (set_r_i == W_RD'(k));
         dec_vec[k] = clr_v_i && (clr_r_i == W_RD'(k));
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_pend
      pend_counter #(
         .W_CNT (W_CNT)
      ) u_cnt (
         .clk    (clk),
         .reset  (reset),
         .inc    (inc_vec[g]),
         .dec    (dec_vec[g]),
         .zero_o (zero_vec[g]),
         .full_o (full_vec[g]),
         .ovf_o  (ovf_vec[g]),
         .unf_o  (unf_vec[g])
      );
   end

   // Hazard uses registered counts only: a same-cycle retire does not bypass.
   assign r0_busy = ~zero_vec[chk_r0_i];
   assign r0_full = full_vec[chk_r0_i];
   assign r1_busy = ~zero_vec[chk_r1_i];

   assign reserved_o = chk_v_i & (r0_busy | (chk_r1en_i & r1_busy) | (chk_wen_i & r0_full));
   assign busy_o     = ~(&zero_vec);

   always_ff @(posedge clk) begin
      if (!reset) begin
         err <= 1'b0;
      end else if ((|ovf_vec) || (|unf_vec)) begin
         err <= 1'b1;
      end
   end

   assign err_o = err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random traffic
// compared against an array-of-counts reference model.
module tb_reg_scoreboard;

   localparam int W_RD  = 3;
   localparam int W_CNT = 2;
   localparam int NREG  = 8;
   localparam int MAXP  = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            chk_v_i;
   logic [W_RD-1:0] chk_r0_i;
   logic [W_RD-1:0] chk_r1_i;
   logic            chk_r1en_i;
   logic            chk_wen_i;
   logic            reserved_o;
   logic            set_v_i;
   logic [W_RD-1:0] set_r_i;
   logic            clr_v_i;
   logic [W_RD-1:0] clr_r_i;
   logic            busy_o;
   logic            err_o;

   int  total = 0;
   int  bad   = 0;
   int  pend[NREG];
   bit  err_m;

   reg_scoreboard #(.W_RD(W_RD), .W_CNT(W_CNT)) dut (
      .clk        (clk),
      .reset      (reset),
      .chk_v_i    (chk_v_i),
      .chk_r0_i   (chk_r0_i),
      .chk_r1_i   (chk_r1_i),
      .chk_r1en_i (chk_r1en_i),
      .chk_wen_i  (chk_wen_i),
      .reserved_o (reserved_o),
      .set_v_i    (set_v_i),
      .set_r_i    (set_r_i),
      .clr_v_i    (clr_v_i),
      .clr_r_i    (clr_r_i),
      .busy_o     (busy_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: drive after the falling edge, check outputs, then advance the model
   // across the rising edge.
   task automatic step(input string tag, input bit rst_n,
                       input bit sv, input int sr, input bit cv, input int cr,
                       input bit chv, input int r0, input int r1,
                       input bit r1en, input bit wen);
      bit exp_res;
      bit exp_busy;
      bit inc;
      bit dec;
      @(negedge clk);
      reset      = rst_n;
      set_v_i    = sv;
      set_r_i    = W_RD'(sr);
      clr_v_i    = cv;
      clr_r_i    = W_RD'(cr);
      chk_v_i    = chv;
      chk_r0_i   = W_RD'(r0);
      chk_r1_i   = W_RD'(r1);
      chk_r1en_i = r1en;
      chk_wen_i  = wen;
      #1;
      exp_res  = chv && (pend[r0] > 0 || (r1en && pend[r1] > 0) || (wen && pend[r0] == MAXP));
      exp_busy = 1'b0;
      foreach (pend[k]) if (pend[k] > 0) exp_busy = 1'b1;
      check({tag, ".reserved"}, reserved_o, exp_res);
      check({tag, ".busy"}, busy_o, exp_busy);
      check({tag, ".err"}, err_o, err_m);
      @(posedge clk);
      if (!rst_n) begin
         foreach (pend[k]) pend[k] = 0;
         err_m = 1'b0;
      end else begin
         for (int k = 0; k < NREG; k++) begin
            inc = sv && sr == k;
            dec = cv && cr == k;
            if (inc && !dec) begin
               if (pend[k] == MAXP) err_m = 1'b1;
               else pend[k] = pend[k] + 1;
            end else if (dec && !inc) begin
               if (pend[k] == 0) err_m = 1'b1;
               else pend[k] = pend[k] - 1;
            end
         end
      end
   endtask

   task automatic idle(input string tag, input int r0, input int r1, input bit r1en, input bit wen);
      step(tag, 1, 0, 0, 0, 0, 1, r0, r1, r1en, wen);
   endtask

   initial begin
      reset = 1'b0; set_v_i = 0; set_r_i = 0; clr_v_i = 0; clr_r_i = 0;
      chk_v_i = 0; chk_r0_i = 0; chk_r1_i = 0; chk_r1en_i = 0; chk_wen_i = 0;
      foreach (pend[k]) pend[k] = 0;
      err_m = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state probe
      idle("rst_probe", 3, 5, 1, 1);

      // Set visible one cycle later, only when operand 1 is a register read
      step("set_r2_n", 1, 1, 2, 0, 0, 1, 0, 2, 1, 0);
      idle("set_r2_n1", 0, 2, 1, 0);
      step("clr_r2", 1, 0, 0, 1, 2, 1, 0, 2, 1, 0);
      step("set_r2b_n", 1, 1, 2, 0, 0, 1, 0, 2, 0, 0);
      idle("set_r2b_n1", 0, 2, 0, 0);
      step("clr_r2b", 1, 0, 0, 1, 2, 0, 0, 0, 0, 0);

      // Fill r4, probe full, overflow
      for (int i = 0; i < 3; i++) step("fill_r4", 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
      idle("full_r4", 4, 0, 0, 1);
      step("ovf_r4", 1, 1, 4, 0, 0, 1, 4, 0, 0, 1);
      idle("ovf_r4_after", 4, 0, 0, 1);
      for (int i = 0; i < 3; i++) step("drain_r4", 1, 0, 0, 1, 4, 1, 4, 0, 0, 0);

      // Reset clears err
      step("rst1", 0, 0, 0, 0, 0, 1, 6, 6, 1, 1);

      // Simultaneous set+clr on r6 holds count
      step("set_r6", 1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
      step("setclr_r6", 1, 1, 6, 1, 6, 1, 6, 0, 0, 0);
      step("clr_r6", 1, 0, 0, 1, 6, 1, 6, 0, 0, 0);
      idle("r6_free", 6, 6, 1, 1);
      step("setclr_empty", 1, 1, 5, 1, 5, 1, 5, 0, 0, 0);
      idle("setclr_empty_after", 5, 5, 1, 1);

      // Underflow, then reset clears it
      step("unf_r1", 1, 0, 0, 1, 1, 1, 1, 1, 1, 0);
      idle("unf_r1_after", 1, 1, 1, 0);
      step("rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle("rst2_after", 1, 1, 1, 1);

      // Reset mid-stream beats a simultaneous set
      for (int k = 0; k < NREG; k++) step("fill_all", 1, 1, k, 0, 0, 1, k, 0, 0, 0);
      step("rst_mid", 0, 1, 0, 0, 0, 1, 0, 7, 1, 1);
      idle("rst_mid_after", 0, 7, 1, 1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step("rand", ($urandom_range(0, 59) != 0),
              $urandom_range(0, 1), $urandom_range(0, NREG - 1),
              $urandom_range(0, 1), $urandom_range(0, NREG - 1),
              $urandom_range(0, 3) != 0, $urandom_range(0, NREG - 1),
              $urandom_range(0, NREG - 1), $urandom_range(0, 1), $urandom_range(0, 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
